dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 98 +++++++++
 tb/tb_dmem_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory with registered read data.
// Fixed three-state sequence per access (IDLE -> ACCESS -> DONE), alternating priority on contention.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_ack,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_ack,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_in,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_out,
  output logic                  busy,
  output logic                  grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state_q, state_d;
  logic                  prio_q, prio_d;
  logic                  grant_q, grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      grant_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      grant_q <= grant_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    grant_d = grant_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    win     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          // Contention resolved by prio; a lone requester wins outright.
          win     = (r0_req && r1_req) ? prio_q : r1_req;
          grant_d = win;
          we_d    = win ? r1_we    : r0_we;
          addr_d  = win ? r1_addr  : r0_addr;
          wdata_d = win ? r1_wdata : r0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = DONE;
      DONE: begin
        prio_d  = ~grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoded from the state register so an async reset drops mem_we at once.
  assign mem_we      = (state_q == ACCESS) && we_q;
  assign mem_address = addr_q;
  assign mem_in      = wdata_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_q;

  assign r0_ack   = (state_q == DONE) && !grant_q;
  assign r1_ack   = (state_q == DONE) &&  grant_q;
  assign r0_rdata = (r0_ack && !we_q) ? mem_out : '0;
  assign r1_rdata = (r1_ack && !we_q) ? mem_out : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: registered memory model plus a
// transaction-level reference (shadow memory and priority pointer).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [9:0]  r0_addr, r1_addr;
  logic [31:0] r0_wdata, r1_wdata;
  logic        r0_ack, r1_ack;
  logic [31:0] r0_rdata, r1_rdata;
  logic [9:0]  mem_address;
  logic [31:0] mem_in;
  logic        mem_we;
  logic [31:0] mem_out;
  logic        busy, grant_id;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] mem [1024] = '{default: 32'd0};
  logic [31:0] ref_mem [1024];
  logic        ref_prio;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_address] <= mem_in;
    mem_out <= mem[mem_address];
  end

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_address(mem_address), .mem_in(mem_in), .mem_we(mem_we), .mem_out(mem_out),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the DUT in IDLE; returns at a falling edge in IDLE.
  task automatic run_txn(input logic q0, input logic w0, input logic [9:0] a0, input logic [31:0] d0,
                         input logic q1, input logic w1, input logic [9:0] a1, input logic [31:0] d1,
                         input bit drop, input bit alter, input string tag);
    logic        win, wwe;
    logic [9:0]  wa;
    logic [31:0] wd, exp_rd;
    r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    #1;
    chk({tag, ".idle_busy"}, 64'(busy), 64'(0));
    chk({tag, ".idle_ack0"}, 64'(r0_ack), 64'(0));
    chk({tag, ".idle_ack1"}, 64'(r1_ack), 64'(0));
    chk({tag, ".idle_we"}, 64'(mem_we), 64'(0));
    @(negedge clk);
    if (!q0 && !q1) begin
      #1;
      chk({tag, ".stay_idle"}, 64'(busy), 64'(0));
    end else begin
      win = (q0 && q1) ? ref_prio : q1;
      wwe = win ? w1 : w0;
      wa  = win ? a1 : a0;
      wd  = win ? d1 : d0;
      if (drop) begin r0_req = 1'b0; r1_req = 1'b0; end
      if (alter) begin
        r0_addr = 10'($urandom); r1_addr = 10'($urandom);
        r0_wdata = $urandom; r1_wdata = $urandom;
        r0_we = ~r0_we; r1_we = ~r1_we;
      end
      #1;
      chk({tag, ".acc_busy"}, 64'(busy), 64'(1));
      chk({tag, ".acc_we"}, 64'(mem_we), 64'(wwe));
      chk({tag, ".acc_addr"}, 64'(mem_address), 64'(wa));
      chk({tag, ".acc_wdata"}, 64'(mem_in), 64'(wd));
      chk({tag, ".acc_grant"}, 64'(grant_id), 64'(win));
      chk({tag, ".acc_acks"}, 64'({r0_ack, r1_ack}), 64'(0));
      @(negedge clk);
      #1;
      exp_rd = wwe ? 32'd0 : ref_mem[wa];
      if (wwe) ref_mem[wa] = wd;
      chk({tag, ".done_ack0"}, 64'(r0_ack), 64'(!win));
      chk({tag, ".done_ack1"}, 64'(r1_ack), 64'(win));
      chk({tag, ".done_rdata0"}, 64'(r0_rdata), win ? 64'(0) : 64'(exp_rd));
      chk({tag, ".done_rdata1"}, 64'(r1_rdata), win ? 64'(exp_rd) : 64'(0));
      chk({tag, ".done_we"}, 64'(mem_we), 64'(0));
      chk({tag, ".done_addr"}, 64'(mem_address), 64'(wa));
      chk({tag, ".done_busy"}, 64'(busy), 64'(1));
      ref_prio = ~win;
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
    ref_prio = 1'b0;
    reset = 1'b1;
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_we", 64'(mem_we), 64'(0));
    chk("rst_acks", 64'({r0_ack, r1_ack}), 64'(0));
    chk("rst_rdata", 64'({r0_rdata, r1_rdata}), 64'(0));
    chk("rst_grant", 64'(grant_id), 64'(0));
    chk("rst_addr", 64'(mem_address), 64'(0));
    chk("rst_wdata", 64'(mem_in), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    // Both requesters held high: r0, r1, r0, r1.
    for (int k = 0; k < 4; k++)
      run_txn(1, 0, 10'(k), 32'd0, 1, 0, 10'(k + 16), 32'd0, 0, 0, "both_held");

    run_txn(1, 1, 10'h2B0, 32'd2001, 0, 0, 10'h0, 32'd0, 0, 0, "r0_write");
    run_txn(0, 0, 10'h0, 32'd0, 1, 0, 10'h2B0, 32'd0, 0, 0, "r1_read");
    run_txn(1, 0, 10'h2B0, 32'd0, 0, 0, 10'h0, 32'd0, 1, 0, "r0_pulse");
    run_txn(0, 0, 10'h0, 32'd0, 0, 0, 10'h0, 32'd0, 0, 0, "after_pulse");
    run_txn(0, 0, 10'h0, 32'd0, 1, 1, 10'h0A0, 32'h1234, 0, 1, "r1_alter");
    run_txn(1, 0, 10'h0A0, 32'd0, 0, 0, 10'h0, 32'd0, 0, 0, "alter_readback");

    // Write abandoned by reset during ACCESS.
    run_txn(0, 0, 10'h0, 32'd0, 1, 1, 10'h155, 32'hAAAA5555, 0, 0, "r1_first_wr");
    r1_req = 1; r1_we = 1; r1_addr = 10'h155; r1_wdata = 32'hDEADBEEF;
    @(negedge clk);
    #1;
    chk("abort_acc_we", 64'(mem_we), 64'(1));
    reset = 1'b1;
    #1;
    chk("abort_we", 64'(mem_we), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_acks", 64'({r0_ack, r1_ack}), 64'(0));
    chk("abort_grant", 64'(grant_id), 64'(0));
    r1_req = 0;
    @(negedge clk);
    reset = 1'b0;
    ref_prio = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("abort_no_ack", 64'({r0_ack, r1_ack}), 64'(0));
    end
    run_txn(1, 0, 10'h155, 32'd0, 0, 0, 10'h0, 32'd0, 0, 0, "abort_readback");

    for (int k = 0; k < 60; k++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              10'(32'h100 + $urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              10'(32'h100 + $urandom_range(0, 7)), $urandom,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
